lt24_bus_writer: RTL

Avalon-MM slave that turns HPS register writes into LT24 (ILI9341) 8080-style parallel write cycles. Sits inside `soc_system` as the `lt24_0` component and drives the LT24 conduit pins at the top level. Command and pixel words are queued in a small FIFO. A sequencer then replays each word on the panel bus with programmable strobe timing.

---
 rtl/lt24_pkg.sv | 38 +++
 rtl/lt24_fifo.sv | 72 +++++++
 rtl/lt24_bus_writer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/lt24_pkg.sv
// lt24_pkg: shared types and constants for the LT24 (ILI9341) parallel bus writer.
package lt24_pkg;

   // One queued panel word: data/command select plus the 16-bit bus value
   typedef struct packed {
      logic        dcx;
      logic [15:0] data;
   } lt24_entry_t;

   localparam int unsigned ENTRY_W = 17;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_WR_LO = 2'd2,
      ST_WR_HI = 2'd3
   } lt24_state_e;

   // Avalon register map
   localparam logic [1:0] ADDR_CMD  = 2'd0;
   localparam logic [1:0] ADDR_DATA = 2'd1;
   localparam logic [1:0] ADDR_CTRL = 2'd2;

   // CTRL write bits
   localparam int unsigned CTRL_ON_BIT    = 0;
   localparam int unsigned CTRL_RST_BIT   = 1;
   localparam int unsigned CTRL_FLUSH_BIT = 2;

   // STATUS read bits
   localparam int unsigned STAT_ON_BIT    = 0;
   localparam int unsigned STAT_RST_BIT   = 1;
   localparam int unsigned STAT_EMPTY_BIT = 2;
   localparam int unsigned STAT_FULL_BIT  = 3;
   localparam int unsigned STAT_BUSY_BIT  = 4;
   localparam int unsigned STAT_LEVEL_LSB = 8;

endpackage

// File: rtl/lt24_fifo.sv
// lt24_fifo: synchronous FIFO without fall-through; flush clears all entries.
// Pop of an empty FIFO and push to a full FIFO are ignored.
module lt24_fifo
   import lt24_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  lt24_entry_t                wdata_i,
   output lt24_entry_t                rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   lt24_entry_t     mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   count_q, count_d;
   logic            do_push_c;
   logic            do_pop_c;

   assign full_o    = (count_q == LW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign level_o   = count_q;
   assign rdata_o   = mem_q[rd_ptr_q];
   assign do_push_c = push_i && !full_o && !flush_i;
   assign do_pop_c  = pop_i && !empty_o && !flush_i;

   // Pointer and occupancy update; flush wins over push/pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push_c && !do_pop_c)      count_d = count_q + LW'(1);
         else if (do_pop_c && !do_push_c) count_d = count_q - LW'(1);
      end
   end

   // Pointer/occupancy registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (do_push_c) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/lt24_bus_writer.sv
// lt24_bus_writer: Avalon-MM slave that replays queued command/pixel words as
// ILI9341 8080-style write cycles with programmable strobe timing.
// Optional macro LT24_CS_HOLD_EN keeps CSX low across back-to-back words.
module lt24_bus_writer #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned CS_SETUP   = 1,
   parameter int unsigned WR_LOW     = 2,
   parameter int unsigned WR_HIGH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  avs_address,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   output logic        avs_waitrequest,
   output logic        lcd_csx_n,
   output logic        lcd_dcx,
   output logic        lcd_wrx_n,
   output logic        lcd_rdx_n,
   output logic [15:0] lcd_data,
   output logic        lcd_on,
   output logic        lcd_reset_n
);

   import lt24_pkg::*;

   localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned MAX_SL = (CS_SETUP > WR_LOW) ? CS_SETUP : WR_LOW;
   localparam int unsigned MAX_PH = (MAX_SL > WR_HIGH) ? MAX_SL : WR_HIGH;
   localparam int unsigned CNT_W  = $clog2(MAX_PH) + 1;

   // FIFO interface
   logic               push_c;
   logic               pop_c;
   logic               flush_c;
   logic               word_avail_c;
   logic               addr_word_c;
   lt24_entry_t        fifo_wdata_c;
   lt24_entry_t        fifo_rdata;
   logic               fifo_full;
   logic               fifo_empty;
   logic [LVL_W-1:0]   fifo_level;

   // Sequencer state and per-phase counters
   lt24_state_e        state_q, state_d;
   logic [CNT_W-1:0]   setup_cnt_q, setup_cnt_d;
   logic [CNT_W-1:0]   lo_cnt_q, lo_cnt_d;
   logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;

   // Registered panel pins
   logic [15:0]        data_q, data_d;
   logic               dcx_q, dcx_d;
   logic               csx_n_q, csx_n_d;
   logic               wrx_n_q, wrx_n_d;
   logic               lcd_on_q;
   logic               lcd_reset_n_q;
   logic [31:0]        readdata_q;
   logic [31:0]        status_c;
   logic               unused_wd_c;

   // Avalon decode
   assign addr_word_c     = (avs_address == ADDR_CMD) || (avs_address == ADDR_DATA);
   assign avs_waitrequest = avs_write && addr_word_c && fifo_full;
   assign push_c          = avs_write && addr_word_c && !fifo_full;
   assign flush_c         = avs_write && (avs_address == ADDR_CTRL) &&
                            avs_writedata[CTRL_FLUSH_BIT];
   assign word_avail_c    = !fifo_empty && !flush_c;
   assign fifo_wdata_c    = '{dcx: (avs_address == ADDR_DATA), data: avs_writedata[15:0]};
   assign unused_wd_c     = ^avs_writedata[31:16];

   lt24_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_c),
      .pop_i   (pop_c),
      .flush_i (flush_c),
      .wdata_i (fifo_wdata_c),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // STATUS word assembly
   always_comb begin
      status_c                  = '0;
      status_c[STAT_ON_BIT]     = lcd_on_q;
      status_c[STAT_RST_BIT]    = lcd_reset_n_q;
      status_c[STAT_EMPTY_BIT]  = fifo_empty;
      status_c[STAT_FULL_BIT]   = fifo_full;
      status_c[STAT_BUSY_BIT]   = (state_q != ST_IDLE);
      status_c[31:STAT_LEVEL_LSB] = 24'(fifo_level);
   end

   // Control register and read-data register
   always_ff @(posedge clk) begin
      if (reset) begin
         lcd_on_q      <= 1'b0;
         lcd_reset_n_q <= 1'b0;
         readdata_q    <= '0;
      end else begin
         if (avs_write && (avs_address == ADDR_CTRL)) begin
            lcd_on_q      <= avs_writedata[CTRL_ON_BIT];
            lcd_reset_n_q <= avs_writedata[CTRL_RST_BIT];
         end
         if (avs_read) begin
            readdata_q <= (avs_address == ADDR_CTRL) ? status_c : 32'h0;
         end
      end
   end

   // Sequencer next state; pin values follow the state being entered
   always_comb begin
      state_d     = state_q;
      setup_cnt_d = setup_cnt_q;
      lo_cnt_d    = lo_cnt_q;
      hi_cnt_d    = hi_cnt_q;
      data_d      = data_q;
      dcx_d       = dcx_q;
      pop_c       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (word_avail_c) begin
               pop_c       = 1'b1;
               data_d      = fifo_rdata.data;
               dcx_d       = fifo_rdata.dcx;
               setup_cnt_d = CNT_W'(CS_SETUP - 1);
               state_d     = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (setup_cnt_q == '0) begin
               lo_cnt_d = CNT_W'(WR_LOW - 1);
               state_d  = ST_WR_LO;
            end else begin
               setup_cnt_d = setup_cnt_q - CNT_W'(1);
            end
         end
         ST_WR_LO: begin
            if (lo_cnt_q == '0) begin
               hi_cnt_d = CNT_W'(WR_HIGH - 1);
               state_d  = ST_WR_HI;
            end else begin
               lo_cnt_d = lo_cnt_q - CNT_W'(1);
            end
         end
         ST_WR_HI: begin
            if (hi_cnt_q == '0) begin
`ifdef LT24_CS_HOLD_EN
               if (word_avail_c) begin
                  pop_c       = 1'b1;
                  data_d      = fifo_rdata.data;
                  dcx_d       = fifo_rdata.dcx;
                  setup_cnt_d = CNT_W'(CS_SETUP - 1);
                  state_d     = ST_SETUP;
               end else begin
                  state_d = ST_IDLE;
               end
`else
               state_d = ST_IDLE;
`endif
            end else begin
               hi_cnt_d = hi_cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      csx_n_d = (state_d == ST_IDLE);
      wrx_n_d = (state_d != ST_WR_LO);
   end

   // Sequencer and panel pin registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         setup_cnt_q <= '0;
         lo_cnt_q    <= '0;
         hi_cnt_q    <= '0;
         data_q      <= '0;
         dcx_q       <= 1'b0;
         csx_n_q     <= 1'b1;
         wrx_n_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         setup_cnt_q <= setup_cnt_d;
         lo_cnt_q    <= lo_cnt_d;
         hi_cnt_q    <= hi_cnt_d;
         data_q      <= data_d;
         dcx_q       <= dcx_d;
         csx_n_q     <= csx_n_d;
         wrx_n_q     <= wrx_n_d;
      end
   end

   assign avs_readdata = readdata_q;
   assign lcd_csx_n    = csx_n_q;
   assign lcd_dcx      = dcx_q;
   assign lcd_wrx_n    = wrx_n_q;
   assign lcd_rdx_n    = 1'b1;
   assign lcd_data     = data_q;
   assign lcd_on       = lcd_on_q;
   assign lcd_reset_n  = lcd_reset_n_q;

endmodule
